// File: rtl/uart_tx_arbiter_if.sv
// Bundle between four transmit requesters, the arbiter and the UART transmitter controller.
// The arbiter takes the master side; requesters and the transmitter take the slave side.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        err;
    logic [1:0]  err_id;
    logic        busy;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_done;

    modport master (
        input  req, req_data, tx_done,
        output ack, grant, err, err_id, busy, tx_send, tx_data
    );

    modport slave (
        output req, req_data, tx_done,
        input  ack, grant, err, err_id, busy, tx_send, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Abandons a frame after TIMEOUT_CYC cycles without a completion report from the transmitter.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);

    state_t      state, state_next;
    logic [3:0]  grant_q, grant_next;
    logic [3:0]  ack_q, ack_next;
    logic        err_q, err_next;
    logic [1:0]  err_id_q, err_id_next;
    logic        busy_q, busy_next;
    logic        tx_send_q, tx_send_next;
    logic [7:0]  tx_data_q, tx_data_next;
    logic [19:0] count_q, count_next;
    logic [1:0]  last_grant_q, last_grant_next;
    logic [1:0]  owner_q, owner_next;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand;

    // Scan upward from the requester after the one last served, so everyone gets a turn.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant_q;
        ack_next        = 4'b0000;
        err_next        = 1'b0;
        err_id_next     = 2'd0;
        tx_data_next    = tx_data_q;
        count_next      = count_q;
        last_grant_next = last_grant_q;
        owner_next      = owner_q;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next   = SEND;
                    owner_next   = win_idx;
                    grant_next   = 4'b0001 << win_idx;
                    tx_data_next = bus.req_data[{win_idx, 3'b000} +: 8];
                    count_next   = 20'd0;
                end
            end
            SEND: begin
                // A completion seen on the timeout cycle still counts as success.
                if (bus.tx_done) begin
                    ack_next        = 4'b0001 << owner_q;
                    last_grant_next = owner_q;
                    state_next      = RELEASE;
                end else if (count_q == TIMEOUT_LAST) begin
                    err_next        = 1'b1;
                    err_id_next     = owner_q;
                    last_grant_next = owner_q;
                    state_next      = RELEASE;
                end else begin
                    count_next = count_q + 20'd1;
                end
            end
            RELEASE: begin
                if (!bus.tx_done) begin
                    state_next = IDLE;
                    grant_next = 4'b0000;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase

        busy_next    = (state_next != IDLE);
        tx_send_next = (state_next == SEND);
    end

    // All outputs come straight from flops so nothing combinational reaches the ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant_q      <= 4'b0000;
            ack_q        <= 4'b0000;
            err_q        <= 1'b0;
            err_id_q     <= 2'd0;
            busy_q       <= 1'b0;
            tx_send_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            count_q      <= 20'd0;
            last_grant_q <= 2'd3;
            owner_q      <= 2'd0;
        end else begin
            state        <= state_next;
            grant_q      <= grant_next;
            ack_q        <= ack_next;
            err_q        <= err_next;
            err_id_q     <= err_id_next;
            busy_q       <= busy_next;
            tx_send_q    <= tx_send_next;
            tx_data_q    <= tx_data_next;
            count_q      <= count_next;
            last_grant_q <= last_grant_next;
            owner_q      <= owner_next;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.err_id  = err_id_q;
    assign bus.busy    = busy_q;
    assign bus.tx_send = tx_send_q;
    assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short timeout so abandon paths are reachable.
module tb_uart_tx_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] order [5];
        logic [7:0] bytes [4];
        checks = 0;
        errors = 0;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset        = 1'b1;
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        bus.tx_done  = 1'b0;
        step();
        step();
        check_output("rst_tx_send", 32'(bus.tx_send), 32'd0);
        check_output("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check_output("rst_grant",   32'(bus.grant),   32'h0);
        check_output("rst_ack",     32'(bus.ack),     32'h0);
        check_output("rst_err",     32'(bus.err),     32'd0);
        check_output("rst_err_id",  32'(bus.err_id),  32'd0);
        check_output("rst_busy",    32'(bus.busy),    32'd0);
        reset = 1'b0;
        step();
        check_output("idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] single frame from requester 0");
        bus.req      = 4'b0001;
        bus.req_data = 32'h000000A5;
        step();
        check_output("t1_tx_send", 32'(bus.tx_send), 32'd1);
        check_output("t1_tx_data", 32'(bus.tx_data), 32'hA5);
        check_output("t1_grant",   32'(bus.grant),   32'h1);
        check_output("t1_busy",    32'(bus.busy),    32'd1);
        bus.tx_done = 1'b1;
        step();
        check_output("t1_ack",     32'(bus.ack),     32'h1);
        check_output("t1_tx_drop", 32'(bus.tx_send), 32'd0);
        bus.req     = 4'b0000;
        bus.tx_done = 1'b0;
        step();
        check_output("t1_ack_once", 32'(bus.ack),   32'h0);
        check_output("t1_grant_clr", 32'(bus.grant), 32'h0);
        check_output("t1_idle",     32'(bus.busy),  32'd0);

        $display("[TB] round robin with all four requesting");
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("rr_grant",   32'(bus.grant),   32'(4'b0001 << order[i]));
            check_output("rr_tx_data", 32'(bus.tx_data), 32'(bytes[order[i]]));
            bus.tx_done = 1'b1;
            step();
            check_output("rr_ack", 32'(bus.ack), 32'(4'b0001 << order[i]));
            check_output("rr_err", 32'(bus.err), 32'd0);
            bus.tx_done = 1'b0;
            step();
            check_output("rr_gap_busy",  32'(bus.busy),  32'd0);
            check_output("rr_gap_grant", 32'(bus.grant), 32'h0);
        end
        bus.req = 4'b0000;
        step();

        $display("[TB] reset in third SEND cycle");
        bus.req = 4'b1000;
        step();
        step();
        step();
        check_output("rs_send3", 32'(bus.tx_send), 32'd1);
        reset   = 1'b1;
        bus.req = 4'b0000;
        step();
        check_output("rs_tx_send", 32'(bus.tx_send), 32'd0);
        check_output("rs_grant",   32'(bus.grant),   32'h0);
        check_output("rs_busy",    32'(bus.busy),    32'd0);
        check_output("rs_ack",     32'(bus.ack),     32'h0);
        check_output("rs_err",     32'(bus.err),     32'd0);
        reset   = 1'b0;
        bus.req = 4'b0010;
        step();
        check_output("rs_next_grant", 32'(bus.grant), 32'h2);
        bus.tx_done = 1'b1;
        step();
        check_output("rs_next_ack", 32'(bus.ack), 32'h2);
        bus.req     = 4'b0000;
        bus.tx_done = 1'b0;
        step();

        $display("[TB] timeout with tx_done stuck low");
        bus.req = 4'b0100;
        step();
        check_output("to_grant", 32'(bus.grant), 32'h4);
        for (int i = 1; i <= 7; i++) begin
            step();
            check_output("to_no_err_early", 32'(bus.err),     32'd0);
            check_output("to_still_send",   32'(bus.tx_send), 32'd1);
        end
        step();
        check_output("to_err",     32'(bus.err),     32'd1);
        check_output("to_err_id",  32'(bus.err_id),  32'd2);
        check_output("to_no_ack",  32'(bus.ack),     32'h0);
        check_output("to_tx_drop", 32'(bus.tx_send), 32'd0);
        bus.req = 4'b0000;
        step();
        check_output("to_err_once", 32'(bus.err),  32'd0);
        check_output("to_idle",     32'(bus.busy), 32'd0);

        $display("[TB] completion on the timeout cycle");
        bus.req = 4'b0001;
        step();
        check_output("tw_grant", 32'(bus.grant), 32'h1);
        for (int i = 1; i <= 7; i++) step();
        bus.tx_done = 1'b1;
        step();
        check_output("tw_ack", 32'(bus.ack), 32'h1);
        check_output("tw_err", 32'(bus.err), 32'd0);
        bus.req     = 4'b0000;
        bus.tx_done = 1'b0;
        step();
        check_output("tw_idle", 32'(bus.busy), 32'd0);

        $display("[TB] long tx_done holds RELEASE");
        bus.req = 4'b1000;
        step();
        check_output("rl_grant", 32'(bus.grant), 32'h8);
        bus.tx_done = 1'b1;
        step();
        check_output("rl_ack", 32'(bus.ack), 32'h8);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("rl_busy",    32'(bus.busy),    32'd1);
            check_output("rl_tx_send", 32'(bus.tx_send), 32'd0);
            check_output("rl_grant_held", 32'(bus.grant), 32'h8);
        end
        bus.tx_done = 1'b0;
        step();
        check_output("rl_idle_busy",  32'(bus.busy),  32'd0);
        check_output("rl_idle_grant", 32'(bus.grant), 32'h0);
        step();
        check_output("rl_regrant", 32'(bus.grant), 32'h8);
        bus.tx_done = 1'b1;
        step();
        check_output("rl_reack", 32'(bus.ack), 32'h8);
        bus.req     = 4'b0000;
        bus.tx_done = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000000: maximum SEND-state cycles before a frame is abandoned; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester transmit request; requester i holds req[i] and its byte until ack[i] or err with err_id=i.
REQ-005 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 ack  output  4  one-cycle pulse on bit i when requester i's frame completes.
REQ-007 grant  output  4  one-hot owner of the transmitter; all-zero when idle.
REQ-008 err  output  1  one-cycle pulse on frame timeout.
REQ-009 err_id  output  2  requester index of the timed-out frame; valid while err=1.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 tx_send  output  1  send strobe to the UART transmitter controller.
REQ-012 tx_data  output  8  byte presented to the transmitter shift-register load.
REQ-013 tx_done  input  1  high while the transmitter sits in its frame-complete state; falls after tx_send drops.

Function
REQ-014 States: IDLE, SEND, RELEASE; 2-bit registered state.
REQ-015 IDLE: if req != 0, pick the winner, latch tx_data from its byte, set grant one-hot, clear the timeout counter, and go to SEND; otherwise stay.
REQ-016 Winner: round-robin; first set req bit scanning upward (mod 4) from last_grant+1.
REQ-017 last_grant updates only on ack or err; it holds the index just served.
REQ-018 Latency: req seen in IDLE at edge t -> tx_send=1 and grant valid from edge t+1.
REQ-019 SEND: tx_send=1 and tx_data stable; timeout counter increments by 1 per cycle; counter is 20 bits.
REQ-020 SEND with tx_done=1: pulse ack[grant] for one cycle, update last_grant, go to RELEASE.
REQ-021 SEND with tx_done=0 and counter == TIMEOUT_CYC-1: pulse err, drive err_id=grant index, no ack, update last_grant, go to RELEASE.
REQ-022 If tx_done=1 and the timeout occur in the same cycle, tx_done wins: ack, no err.
REQ-023 RELEASE: tx_send=0; stay until tx_done=0, then go to IDLE with grant cleared.
REQ-024 tx_send is never high outside SEND; tx_data changes only on the IDLE->SEND transition.
REQ-025 A req bit dropped mid-frame does not abort the frame; ack still pulses on completion.
REQ-026 New requests arriving during SEND/RELEASE are ignored until IDLE; minimum gap between frames is one IDLE cycle.
REQ-027 At most one ack bit and never both ack and err in the same cycle.
REQ-028 ack, err, grant, tx_send and busy are registered outputs; there are no combinational paths from inputs to outputs.

Reset
REQ-029 reset=1 at an edge forces state=IDLE, tx_send=0, tx_data=0, grant=0, ack=0, err=0, err_id=0, busy=0, counter=0, last_grant=3.
REQ-030 Reset during SEND or RELEASE abandons the frame with no ack and no err; tx_send is low from the next edge.
REQ-031 Reset has priority over every other transition.

Verification
REQ-032 After reset, req=4'b0001 and byte0=8'hA5 -> next edge: tx_send=1, tx_data=8'hA5, grant=4'b0001; tx_done pulse -> ack=4'b0001 for one cycle.
REQ-033 req=4'b1111 held, tx_done model completing each frame -> grant order 0,1,2,3,0, one IDLE cycle between frames.
REQ-034 TIMEOUT_CYC=8, req=4'b0100, tx_done stuck 0 -> err=1 and err_id=2 exactly 8 SEND cycles after tx_send rises, no ack, then IDLE.
REQ-035 tx_done asserted on the timeout cycle (TIMEOUT_CYC=8) -> ack pulses, err stays 0.
REQ-036 reset asserted in the 3rd SEND cycle -> next edge: tx_send=0, grant=0, busy=0, no ack or err; a subsequent req=4'b0010 is served first.
REQ-037 tx_done held high for 5 cycles after tx_send drops -> state stays RELEASE 5 cycles, busy=1, no new grant despite req=4'b1000.
